// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexed scan of a packed digit word
// onto one shared hex-to-7-segment decoder, with guard gaps, blank and blink.
module display_scan_controller #(
    parameter int DIGITS       = 6,
    parameter int SHOW_CYCLES  = 2000,
    parameter int GUARD_CYCLES = 50,
    parameter int BLINK_FRAMES = 100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            binary_out,
    output logic                  _enable_out,
    output logic [DIGITS-1:0]     digit_sel_out,
    output logic                  frame_start
);

    localparam int MAXC = (SHOW_CYCLES > GUARD_CYCLES) ? SHOW_CYCLES
                                                       : GUARD_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {
        SHOW,
        GUARD
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   snap_digits;
    logic [DIGITS-1:0]     snap_blank;
    logic [DIGITS-1:0]     snap_blink;
    logic [BW-1:0]         blink_cnt;
    logic                  phase;
    logic                  started;

    logic                  terminal;
    logic                  wrap;
    logic [IW-1:0]         idx_n;
    logic [4*DIGITS-1:0]   digits_n;
    logic [DIGITS-1:0]     blank_n;
    logic [DIGITS-1:0]     blink_n;
    logic [3:0]            nib_n;
    logic                  en_n;
    logic [BW-1:0]         blink_cnt_n;
    logic                  phase_n;

    // Next-digit selection; at a frame wrap the fresh inputs are used
    // directly since the snapshot loads on the same edge.
    always_comb begin
        terminal    = (state == SHOW) ? (cnt == CW'(SHOW_CYCLES - 1))
                                      : (cnt == CW'(GUARD_CYCLES - 1));
        wrap        = terminal && (state == GUARD)
                      && (idx == IW'(DIGITS - 1));
        idx_n       = wrap ? '0 : idx + IW'(1);
        digits_n    = wrap ? digits_in  : snap_digits;
        blank_n     = wrap ? blank_mask : snap_blank;
        blink_n     = wrap ? blink_mask : snap_blink;
        blink_cnt_n = blink_cnt;
        phase_n     = phase;
        if (wrap && started) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_n = '0;
                phase_n     = ~phase;
            end else begin
                blink_cnt_n = blink_cnt + BW'(1);
            end
        end
        nib_n = digits_n[{idx_n, 2'b00} +: 4];
        en_n  = blank_n[idx_n] | (blink_n[idx_n] & phase_n);
    end

    // Scan FSM with registered decoder and select outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= GUARD;
            cnt           <= '0;
            idx           <= IW'(DIGITS - 1);
            snap_digits   <= '0;
            snap_blank    <= '0;
            snap_blink    <= '0;
            blink_cnt     <= '0;
            phase         <= 1'b0;
            started       <= 1'b0;
            binary_out    <= 4'h0;
            _enable_out   <= 1'b1;
            digit_sel_out <= '1;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (terminal) begin
                cnt <= '0;
                if (state == SHOW) begin
                    state         <= GUARD;
                    digit_sel_out <= '1;
                    _enable_out   <= 1'b1;
                end else begin
                    state         <= SHOW;
                    idx           <= idx_n;
                    digit_sel_out <= ~(DIGITS'(1) << idx_n);
                    binary_out    <= nib_n;
                    _enable_out   <= en_n;
                    frame_start   <= wrap;
                    if (wrap) begin
                        snap_digits <= digits_in;
                        snap_blank  <= blank_mask;
                        snap_blink  <= blink_mask;
                        blink_cnt   <= blink_cnt_n;
                        phase       <= phase_n;
                        started     <= 1'b1;
                    end
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: scoreboard bench, DIGITS=4, SHOW=3,
// GUARD=1, BLINK_FRAMES=2.
module tb_display_scan_controller;

    logic        clock;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  binary_out;
    logic        _enable_out;
    logic [3:0]  digit_sel_out;
    logic        frame_start;

    display_scan_controller #(
        .DIGITS(4),
        .SHOW_CYCLES(3),
        .GUARD_CYCLES(1),
        .BLINK_FRAMES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .digits_in(digits_in),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .binary_out(binary_out),
        ._enable_out(_enable_out),
        .digit_sel_out(digit_sel_out),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] bin;
        logic       en;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Expected digit entries for frame k (first nd digits of it).
    task automatic push_frame(input int k, input logic [15:0] d,
                              input logic [3:0] bl, input logic [3:0] bk,
                              input int nd);
        exp_t e;
        logic ph;
        ph = ((k / 2) % 2) == 1;
        for (int i = 0; i < nd; i++) begin
            e.sel = ~(4'b0001 << i);
            e.bin = d[4*i +: 4];
            e.en  = bl[i] | (bk[i] & ph);
            e.fs  = (i == 0);
            q.push_back(e);
        end
    endtask

    // Monitor: pops one entry at the start of each SHOW run.
    initial begin
        int   run;
        int   gap;
        exp_t e;
        run = 0;
        gap = -1;
        e   = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                run = 0;
                gap = -1;
            end else if (digit_sel_out != 4'hF) begin
                if (run == 0) begin
                    if (gap >= 0) chk("guard_len", gap, 1);
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_underflow: got sel %b expected none",
                                 digit_sel_out);
                        e = '{sel: 4'hF, bin: 4'h0, en: 1'b1, fs: 1'b0};
                    end else begin
                        e = q.pop_front();
                    end
                end
                chk("sel", int'(digit_sel_out), int'(e.sel));
                chk("bin", int'(binary_out), int'(e.bin));
                chk("en", int'(_enable_out), int'(e.en));
                chk("frame_start", int'(frame_start),
                    int'(e.fs && run == 0));
                run++;
                gap = 0;
            end else begin
                chk("guard_en", int'(_enable_out), 1);
                chk("guard_fs", int'(frame_start), 0);
                if (run > 0) chk("show_len", run, 3);
                if (gap >= 0) gap++;
                run = 0;
            end
        end
    end

    // Stimulus: edges are counted from the release of reset.
    initial begin
        reset      = 1'b1;
        digits_in  = 16'h4321;
        blank_mask = 4'b0000;
        blink_mask = 4'b0001;
        repeat (3) @(negedge clock);
        chk("rst_sel", int'(digit_sel_out), 15);
        chk("rst_en", int'(_enable_out), 1);
        chk("rst_bin", int'(binary_out), 0);
        chk("rst_fs", int'(frame_start), 0);

        push_frame(0, 16'h4321, 4'b0000, 4'b0001, 4);
        push_frame(1, 16'h4321, 4'b0000, 4'b0001, 4);
        push_frame(2, 16'h9876, 4'b0000, 4'b0001, 4);
        push_frame(3, 16'h9876, 4'b0010, 4'b0001, 4);
        push_frame(4, 16'h9876, 4'b0010, 4'b0001, 4);
        push_frame(5, 16'h9876, 4'b0010, 4'b0001, 4);
        push_frame(6, 16'h9876, 4'b0010, 4'b0001, 3);

        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rel_sel", int'(digit_sel_out), 15);
        chk("rel_en", int'(_enable_out), 1);

        repeat (21) @(negedge clock);
        digits_in = 16'h9876;
        repeat (19) @(negedge clock);
        blank_mask = 4'b0010;
        repeat (66) @(negedge clock);

        #2 reset = 1'b1;
        #1;
        chk("mid_rst_sel", int'(digit_sel_out), 15);
        chk("mid_rst_en", int'(_enable_out), 1);
        chk("mid_rst_bin", int'(binary_out), 0);
        chk("mid_rst_fs", int'(frame_start), 0);
        chk("mid_rst_queue", q.size(), 0);

        push_frame(0, 16'h9876, 4'b0010, 4'b0001, 4);
        push_frame(1, 16'h9876, 4'b0010, 4'b0001, 4);

        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rel2_sel", int'(digit_sel_out), 15);
        repeat (32) @(negedge clock);
        #1;
        chk("end_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
